word_lane_packer: RTL and testbench



---
 rtl/word_lane_packer.sv | 121 ++++++++++++
 tb/tb_word_lane_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_lane_packer.sv
// word_lane_packer
//    Packs a stream of WORD_W-bit words into one LANES-wide parallel word.
//    Two ping-pong banks are used: one bank fills from the stream while the
//    other is held for the consumer. A packet may be closed early with in_last.
//
//    Ports:
//       clk        clock, all state updates on the rising edge
//       reset      synchronous, active-high reset
//       in_data    stream word
//       in_valid   in_data is valid
//       in_last    final word of the packet (qualified by in_valid)
//       in_ready   a word can be accepted this cycle
//       out_lanes  packed word, lane i at [WORD_W*i +: WORD_W], lane 0 first
//       out_count  number of valid lanes, 1..LANES
//       out_valid  out_lanes / out_count are valid
//       out_ready  consumer accepts the packed word
//
//    Build option:
//       WORD_LANE_PACKER_ZERO_PAD_EN  when defined, lanes at index >= out_count
//       are forced to 0 at the output. When undefined, those lanes show stale
//       bank contents and the consumer must honour out_count.
module word_lane_packer #(
   parameter int WORD_W = 32,
   parameter int LANES  = 8,
   parameter int CNT_W  = $clog2(LANES + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WORD_W-1:0]       in_data,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [LANES*WORD_W-1:0] out_lanes,
   output logic [CNT_W-1:0]        out_count,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int IDX_W = $clog2(LANES);

   logic [WORD_W-1:0] bank_q [2][LANES];
   logic [WORD_W-1:0] bank_d [2][LANES];
   logic [1:0]        full_q, full_d;
   logic [CNT_W-1:0]  cnt_q [2];
   logic [CNT_W-1:0]  cnt_d [2];
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;

   logic accept;
   logic pop;
   logic close_bank;

   // in_ready depends on registers and reset only, never on in_valid.
   assign in_ready   = !full_q[wr_bank_q] && !reset;
   assign out_valid  = full_q[rd_bank_q];
   assign out_count  = cnt_q[rd_bank_q];
   assign accept     = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign close_bank = in_last || (wr_idx_q == IDX_W'(LANES - 1));

   always_comb begin
      bank_d    = bank_q;
      full_d    = full_q;
      cnt_d     = cnt_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;

      if (accept) begin
         bank_d[wr_bank_q][wr_idx_q] = in_data;
         if (close_bank) begin
            full_d[wr_bank_q] = 1'b1;
            cnt_d[wr_bank_q]  = CNT_W'(wr_idx_q) + CNT_W'(1);
            wr_idx_d          = '0;
            wr_bank_d         = !wr_bank_q;
         end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
         end
      end

      // An accepting bank is never full and the popped bank always is, so
      // the two updates to full_d always touch different entries.
      if (pop) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < LANES; l++) begin
               bank_q[b][l] <= '0;
            end
            cnt_q[b] <= '0;
         end
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_idx_q  <= '0;
      end else begin
         bank_q    <= bank_d;
         cnt_q     <= cnt_d;
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_idx_q  <= wr_idx_d;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef WORD_LANE_PACKER_ZERO_PAD_EN
      assign out_lanes[WORD_W*gi +: WORD_W] =
         (CNT_W'(gi) < out_count) ? bank_q[rd_bank_q][gi] : '0;
`else
      assign out_lanes[WORD_W*gi +: WORD_W] = bank_q[rd_bank_q][gi];
`endif
   end

endmodule

// File: tb/tb_word_lane_packer.sv
module tb_word_lane_packer;

   localparam int WORD_W = 32;
   localparam int LANES  = 8;
   localparam int CNT_W  = $clog2(LANES + 1);
   localparam int OUT_W  = LANES * WORD_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [OUT_W-1:0]  out_lanes;
   logic [CNT_W-1:0]  out_count;
   logic              out_valid;
   logic              out_ready;

   word_lane_packer #(.WORD_W(WORD_W), .LANES(LANES)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_lanes (out_lanes),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = !clk;

   typedef struct {
      logic [OUT_W-1:0] lanes;
      int               cnt;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model of the two banks, fed by the stimulus.
   logic [WORD_W-1:0] m_bank [2][LANES];
   int                m_wb;
   int                m_idx;

   task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int l = 0; l < LANES; l++)
            m_bank[b][l] = '0;
      m_wb  = 0;
      m_idx = 0;
   endtask

   task automatic model_accept(input logic [WORD_W-1:0] d, input logic last);
      exp_t e;
      m_bank[m_wb][m_idx] = d;
      if (last || m_idx == LANES - 1) begin
         e.cnt = m_idx + 1;
         for (int l = 0; l < LANES; l++) begin
`ifdef WORD_LANE_PACKER_ZERO_PAD_EN
            e.lanes[WORD_W*l +: WORD_W] = (l < e.cnt) ? m_bank[m_wb][l] : '0;
`else
            e.lanes[WORD_W*l +: WORD_W] = m_bank[m_wb][l];
`endif
         end
         sb.push_back(e);
         $display("expect packet count=%0d lanes=%h", e.cnt, e.lanes);
         m_wb  = 1 - m_wb;
         m_idx = 0;
      end else begin
         m_idx++;
      end
   endtask

   // Called and returns at posedge+#1. waits = cycles spent with in_ready=0.
   task automatic send_word(input logic [WORD_W-1:0] d, input logic last, output int waits);
      bit done = 0;
      waits    = 0;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            model_accept(d, last);
            done = 1;
         end else begin
            @(posedge clk);
            #1;
            waits++;
            if (waits > 60) begin
               checks++;
               errors++;
               $display("FAIL send_timeout: word %h not accepted in %0d cycles", d, waits);
               done = 1;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", OUT_W'(sb.size()), '0);
   endtask

   // Monitor: pops the scoreboard on every handshake and checks that a
   // stalled output does not change.
   bit               hold_vld = 0;
   logic [OUT_W-1:0] hold_lanes;
   logic [CNT_W-1:0] hold_count;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         hold_vld = 0;
      end else begin
         if (hold_vld) begin
            chk("hold_lanes", out_lanes, hold_lanes);
            chk("hold_count", OUT_W'(out_count), OUT_W'(hold_count));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got count=%0d lanes=%h expected none", out_count, out_lanes);
            end else begin
               e = sb.pop_front();
               $display("pop packet count=%0d lanes=%h", out_count, out_lanes);
               chk("pkt_count", OUT_W'(out_count), OUT_W'(e.cnt));
               chk("pkt_lanes", out_lanes, e.lanes);
            end
         end
         hold_vld   = out_valid && !out_ready;
         hold_lanes = out_lanes;
         hold_count = out_count;
      end
   end

   initial begin
      int w;
      int stalls;
      reset     = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready_low", OUT_W'(in_ready), '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", OUT_W'(out_valid), '0);
      chk("rst_out_count", OUT_W'(out_count), '0);
      chk("rst_out_lanes", out_lanes, '0);
      chk("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
      @(posedge clk);
      #1;

      // Full packet, back to back, out_ready=1
      out_ready = 1'b1;
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         send_word(WORD_W'(32'h10 + i), 1'b0, w);
         stalls += w;
      end
      @(negedge clk);
      chk("full_latency_valid", OUT_W'(out_valid), OUT_W'(1));
      chk("full_count", OUT_W'(out_count), OUT_W'(8));
      chk("full_no_stall", OUT_W'(stalls), '0);
      @(posedge clk);
      #1;
      wait_drain();

      // Partial packet into bank 1
      send_word(32'hA0, 1'b0, w);
      send_word(32'hA1, 1'b0, w);
      send_word(32'hA2, 1'b1, w);
      wait_drain();

      // Single-word packet into bank 0 (bank 0 holds 0x10..0x17 from before)
      send_word(32'h55, 1'b1, w);
      wait_drain();

      // Back-pressure: both banks fill, then a single pop frees one
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_word(WORD_W'(32'h200 + i), 1'b0, w);
      in_data  = 32'h210;
      in_last  = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", OUT_W'(in_ready), '0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_in_ready_after_pop", OUT_W'(in_ready), OUT_W'(1));
      @(posedge clk);
      #1;
      model_accept(32'h210, 1'b0);
      in_valid = 1'b0;
      for (int i = 17; i < 24; i++) send_word(WORD_W'(32'h200 + i), 1'b0, w);
      out_ready = 1'b1;
      wait_drain();

      // Sustained stream
      stalls = 0;
      for (int i = 0; i < 64; i++) begin
         send_word(WORD_W'(32'h1000 + i), 1'b0, w);
         stalls += w;
      end
      chk("stream_no_stall", OUT_W'(stalls), '0);
      wait_drain();

      // Reset with bank 1 full and 5 words in bank 0
      send_word(32'h77, 1'b1, w);
      wait_drain();
      out_ready = 1'b0;
      for (int i = 0; i < 13; i++) send_word(WORD_W'(32'h300 + i), 1'b0, w);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", OUT_W'(in_ready), '0);
      @(posedge clk);
      #1;
      sb.delete();
      model_reset();
      @(negedge clk);
      chk("mid_rst_out_valid", OUT_W'(out_valid), '0);
      chk("mid_rst_out_count", OUT_W'(out_count), '0);
      chk("mid_rst_out_lanes", out_lanes, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_word(32'hC0, 1'b0, w);
      send_word(32'hC1, 1'b1, w);
      wait_drain();

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
